fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage RV32I core.
- Tracks register-use metadata of the instructions in EX, MEM and WB.
- Drives the select inputs of the two 3-input 32-bit ALU operand muxes: 00 = register file, 01 = WB result, 10 = MEM result.
- Detects load-use hazards and stalls IF/ID for one cycle, inserting a bubble into EX; honours branch flush from EX.

---
 rtl/fwd_hazard_ctrl_if.sv | 35 +++
 rtl/fwd_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// Forwarding/hazard controller bus: ID-stage metadata and flush in,
// operand-mux selects, stall, bubble flag and stall counter out.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  stall;
  logic                  ex_bubble;
  logic [CNT_W-1:0]      stall_count;

  // Core side: presents the decoded instruction, consumes the controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_a_sel, fwd_b_sel, stall, ex_bubble, stall_count
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    output fwd_a_sel, fwd_b_sel, stall, ex_bubble, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage RV32I core.
// Keeps register-use metadata for EX, MEM and WB; operand selects are
// 00 = register file, 01 = WB result, 10 = MEM result.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  // EX stage metadata
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
  logic                  ex_uses_rs1_q, ex_uses_rs1_d;
  logic                  ex_uses_rs2_q, ex_uses_rs2_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_mem_read_q, ex_mem_read_d;

  // MEM stage metadata (its load flag only matters while it sits in EX)
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_reg_write_q, mem_reg_write_d;

  // WB stage metadata
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_reg_write_q, wb_reg_write_d;

  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic                  mem_writes, wb_writes;
  logic                  mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
  logic                  ex_load_wr, id_dep_ex;
  logic                  stall_w;
  logic [1:0]            fwd_a_w, fwd_b_w;

  // Writer qualification and load-use detection; x0 never qualifies
  always_comb begin
    mem_writes  = mem_valid_q & mem_reg_write_q & (mem_rd_q != '0);
    wb_writes   = wb_valid_q & wb_reg_write_q & (wb_rd_q != '0);
    mem_hit_rs1 = mem_writes & (mem_rd_q == ex_rs1_q);
    mem_hit_rs2 = mem_writes & (mem_rd_q == ex_rs2_q);
    wb_hit_rs1  = wb_writes & (wb_rd_q == ex_rs1_q);
    wb_hit_rs2  = wb_writes & (wb_rd_q == ex_rs2_q);
    ex_load_wr  = ex_valid_q & ex_mem_read_q & ex_reg_write_q & (ex_rd_q != '0);
    id_dep_ex   = (bus.id_uses_rs1 & (bus.id_rs1 == ex_rd_q)) |
                  (bus.id_uses_rs2 & (bus.id_rs2 == ex_rd_q));
    stall_w     = bus.id_valid & ~bus.flush & ex_load_wr & id_dep_ex;
  end

  // Operand mux selects; MEM holds the younger value so it wins over WB
  always_comb begin
    fwd_a_w = 2'b00;
    fwd_b_w = 2'b00;
    if (ex_uses_rs1_q) begin
      if (mem_hit_rs1)     fwd_a_w = 2'b10;
      else if (wb_hit_rs1) fwd_a_w = 2'b01;
    end
    if (ex_uses_rs2_q) begin
      if (mem_hit_rs2)     fwd_b_w = 2'b10;
      else if (wb_hit_rs2) fwd_b_w = 2'b01;
    end
  end

  // Pipeline advance: MEM and WB always move; EX takes a cleared bubble on flush/stall
  always_comb begin
    ex_valid_d      = bus.id_valid;
    ex_rs1_d        = bus.id_rs1;
    ex_rs2_d        = bus.id_rs2;
    ex_uses_rs1_d   = bus.id_uses_rs1;
    ex_uses_rs2_d   = bus.id_uses_rs2;
    ex_rd_d         = bus.id_rd;
    ex_reg_write_d  = bus.id_reg_write;
    ex_mem_read_d   = bus.id_mem_read;
    mem_valid_d     = ex_valid_q;
    mem_rd_d        = ex_rd_q;
    mem_reg_write_d = ex_reg_write_q;
    wb_valid_d      = mem_valid_q;
    wb_rd_d         = mem_rd_q;
    wb_reg_write_d  = mem_reg_write_q;
    stall_cnt_d     = stall_cnt_q;
    if (bus.flush || stall_w) begin
      ex_valid_d     = 1'b0;
      ex_rs1_d       = '0;
      ex_rs2_d       = '0;
      ex_uses_rs1_d  = 1'b0;
      ex_uses_rs2_d  = 1'b0;
      ex_rd_d        = '0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end
    if (stall_w) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Metadata and counter registers; reset drops all in-flight instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_rs1_q        <= '0;
      ex_rs2_q        <= '0;
      ex_uses_rs1_q   <= 1'b0;
      ex_uses_rs2_q   <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rs1_q        <= ex_rs1_d;
      ex_rs2_q        <= ex_rs2_d;
      ex_uses_rs1_q   <= ex_uses_rs1_d;
      ex_uses_rs2_q   <= ex_uses_rs2_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= mem_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign bus.fwd_a_sel   = fwd_a_w;
  assign bus.fwd_b_sel   = fwd_b_w;
  assign bus.stall       = stall_w;
  assign bus.ex_bubble   = ~ex_valid_q;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, mid-stream reset,
// and random instruction streams against a pipeline-of-records model.
module tb_fwd_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus();

  fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
  } ins_t;

  typedef struct {
    ins_t        ins;
    logic        fl;
    logic [1:0]  ea;
    logic [1:0]  eb;
    logic        es;
    logic        ebub;
    int unsigned ecnt;
  } vec_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  ins_t        pipe [3];
  int unsigned m_cnt;

  function automatic ins_t mk(input int rs1, input bit u1, input int rs2, input bit u2,
                              input int rd, input bit rw, input bit mr);
    ins_t i;
    i.v   = 1'b1;
    i.rs1 = RW'(rs1);
    i.rs2 = RW'(rs2);
    i.u1  = u1;
    i.u2  = u2;
    i.rd  = RW'(rd);
    i.rw  = rw;
    i.mr  = mr;
    return i;
  endfunction

  function automatic vec_t mkv(input ins_t i, input bit fl, input int ea, input int eb,
                               input bit es, input bit ebub, input int unsigned ecnt);
    vec_t v;
    v.ins  = i;
    v.fl   = fl;
    v.ea   = 2'(ea);
    v.eb   = 2'(eb);
    v.es   = es;
    v.ebub = ebub;
    v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic drive(input ins_t i, input logic fl);
    bus.id_valid     = i.v;
    bus.id_rs1       = i.rs1;
    bus.id_rs2       = i.rs2;
    bus.id_uses_rs1  = i.u1;
    bus.id_uses_rs2  = i.u2;
    bus.id_rd        = i.rd;
    bus.id_reg_write = i.rw;
    bus.id_mem_read  = i.mr;
    bus.flush        = fl;
  endtask

  function automatic bit writes(input ins_t s, input logic [RW-1:0] r);
    return s.v && s.rw && (s.rd != 0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] m_sel(input logic used, input logic [RW-1:0] r);
    if (!used) return 2'b00;
    if (writes(pipe[1], r)) return 2'b10;
    if (writes(pipe[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall(input ins_t id, input logic fl);
    return id.v && !fl && pipe[0].mr &&
           ((id.u1 && writes(pipe[0], id.rs1)) || (id.u2 && writes(pipe[0], id.rs2)));
  endfunction

  task automatic model_check(input ins_t id, input logic fl, input string tag);
    chk({tag, "_a"}, 32'(bus.fwd_a_sel), 32'(m_sel(pipe[0].u1, pipe[0].rs1)));
    chk({tag, "_b"}, 32'(bus.fwd_b_sel), 32'(m_sel(pipe[0].u2, pipe[0].rs2)));
    chk({tag, "_stall"}, 32'(bus.stall), 32'(m_stall(id, fl)));
    chk({tag, "_bubble"}, 32'(bus.ex_bubble), 32'(!pipe[0].v));
    chk({tag, "_cnt"}, bus.stall_count, m_cnt);
    // a live EX instruction must never take a MEM-forwarded value from a load
    chk({tag, "_no_load_fwd"},
        32'(!bus.ex_bubble && pipe[1].v && pipe[1].mr &&
            (bus.fwd_a_sel == 2'b10 || bus.fwd_b_sel == 2'b10)), 32'd0);
  endtask

  task automatic model_step(input ins_t id, input logic fl);
    bit st;
    st = m_stall(id, fl);
    if (st) m_cnt++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (st || fl) ? ins_t'('0) : id;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    m_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    ins_t nop, add5, add6, sub7, lw8, add9, lw0, add10, c11, add9d, id;
    logic fl;
    bit   held;

    nop   = '0;
    add5  = mk(1, 1, 2, 1, 5, 1, 0);
    add6  = mk(5, 1, 5, 1, 6, 1, 0);
    sub7  = mk(5, 1, 0, 1, 7, 1, 0);
    lw8   = mk(1, 1, 0, 0, 8, 1, 1);
    add9  = mk(0, 1, 8, 1, 9, 1, 0);
    lw0   = mk(1, 1, 0, 0, 0, 1, 1);
    add10 = mk(0, 1, 0, 1, 10, 1, 0);
    c11   = mk(3, 1, 8, 0, 11, 1, 0);
    add9d = mk(8, 1, 8, 1, 9, 1, 0);

    //                ins    fl  a  b  st bub cnt
    vecs.push_back(mkv(add5,  0, 0, 0, 0, 1, 0));  // EX->EX forward
    vecs.push_back(mkv(add6,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(nop,   0, 2, 2, 0, 0, 0));
    vecs.push_back(mkv(nop,   0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(add5,  0, 0, 0, 0, 1, 0));  // MEM beats WB
    vecs.push_back(mkv(add5,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(sub7,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(nop,   0, 2, 0, 0, 0, 0));
    vecs.push_back(mkv(add5,  0, 0, 0, 0, 1, 0));  // WB forward
    vecs.push_back(mkv(nop,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(sub7,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(nop,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(lw8,   0, 0, 0, 0, 1, 0));  // load-use
    vecs.push_back(mkv(add9,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(add9,  0, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(nop,   0, 0, 1, 0, 0, 1));
    vecs.push_back(mkv(lw0,   0, 0, 0, 0, 1, 1));  // x0 load
    vecs.push_back(mkv(add10, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(nop,   0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(lw8,   0, 0, 0, 0, 1, 1));  // unused rs2
    vecs.push_back(mkv(c11,   0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(nop,   0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(lw8,   0, 0, 0, 0, 1, 1));  // flush beats stall
    vecs.push_back(mkv(add9,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(nop,   0, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(lw8,   0, 0, 0, 0, 1, 1));  // double hazard
    vecs.push_back(mkv(add9d, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mkv(add9d, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mkv(nop,   0, 1, 1, 0, 0, 2));

    drive(nop, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_a", 32'(bus.fwd_a_sel), 32'd0);
    chk("rst_b", 32'(bus.fwd_b_sel), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_bubble", 32'(bus.ex_bubble), 32'd1);
    chk("rst_cnt", bus.stall_count, 32'd0);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ins, vecs[i].fl);
      #1;
      chk($sformatf("v%0d_a", i), 32'(bus.fwd_a_sel), 32'(vecs[i].ea));
      chk($sformatf("v%0d_b", i), 32'(bus.fwd_b_sel), 32'(vecs[i].eb));
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].es));
      chk($sformatf("v%0d_bubble", i), 32'(bus.ex_bubble), 32'(vecs[i].ebub));
      chk($sformatf("v%0d_cnt", i), bus.stall_count, vecs[i].ecnt);
    end

    // Mid-stream reset with live EX/MEM contents and a non-zero counter
    @(negedge clk); drive(add5, 1'b0);
    @(negedge clk); drive(add6, 1'b0);
    @(negedge clk); drive(lw8, 1'b0);
    #1;
    chk("pre_rst_a", 32'(bus.fwd_a_sel), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_a", 32'(bus.fwd_a_sel), 32'd0);
    chk("mid_rst_b", 32'(bus.fwd_b_sel), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    chk("mid_rst_bubble", 32'(bus.ex_bubble), 32'd1);
    chk("mid_rst_cnt", bus.stall_count, 32'd0);
    drive(nop, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Random streams over x0..x3 so hazards are frequent
    held = 1'b0;
    id   = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!held) begin
        id.v   = ($urandom_range(7) != 0);
        id.rs1 = RW'($urandom_range(3));
        id.rs2 = RW'($urandom_range(3));
        id.u1  = 1'($urandom_range(1));
        id.u2  = 1'($urandom_range(1));
        id.rd  = RW'($urandom_range(3));
        id.rw  = ($urandom_range(3) != 0);
        id.mr  = ($urandom_range(2) == 0);
      end
      fl = ($urandom_range(9) == 0);
      @(negedge clk);
      drive(id, fl);
      #1;
      model_check(id, fl, $sformatf("r%0d", n));
      held = m_stall(id, fl);
      model_step(id, fl);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
